// File: rtl/ram_word_port.sv
// rtl/ram_word_port.sv - 8/16/32-bit load/store bridge onto an 8-bit synchronous RAM
module ram_word_port #(
    parameter int ADDR_WIDTH = 17
) (
    input  logic                  clk_in,
    input  logic                  reset,
    input  logic                  ram_ready,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [1:0]            req_size,
    input  logic                  req_signed,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  resp_valid,
    output logic [31:0]           resp_rdata,
    output logic                  ram_en,
    output logic                  ram_r_nw,
    output logic [ADDR_WIDTH-1:0] ram_a,
    output logic [7:0]            ram_dout,
    input  logic [7:0]            ram_din
);

    typedef enum logic [1:0] {
        IDLE,
        READ,
        WRITE,
        RESP
    } state_t;

    state_t                  state, state_nxt;
    logic [2:0]              k, k_nxt, k_inc;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [1:0]              size_q;
    logic                    signed_q;
    logic [31:0]             wdata_q;
    logic [31:0]             rbuf, rbuf_nxt;
    logic [2:0]              n_bytes;
    logic [1:0]              lane;
    logic [31:0]             wshift;
    logic                    handshake;

    logic                    en_nxt, r_nw_nxt;
    logic [ADDR_WIDTH-1:0]   a_nxt;
    logic [7:0]              dout_nxt;
    logic [31:0]             rdata_nxt;

    assign req_ready  = (state == IDLE) && ram_ready && !reset;
    assign resp_valid = (state == RESP) && !reset;
    assign handshake  = req_valid && req_ready;

    assign n_bytes = (size_q == 2'd0) ? 3'd1 : (size_q == 2'd1) ? 3'd2 : 3'd4;
    assign k_inc   = k + 3'd1;
    // Read data arriving while counter is k belongs to the byte issued one cycle earlier.
    assign lane    = k[1:0] - 2'd1;
    assign wshift  = wdata_q >> {k_inc[1:0], 3'b000};

    always_comb begin
        state_nxt = state;
        k_nxt     = k;
        rbuf_nxt  = rbuf;
        en_nxt    = 1'b0;
        r_nw_nxt  = 1'b1;
        a_nxt     = ram_a;
        dout_nxt  = ram_dout;
        rdata_nxt = resp_rdata;
        case (state)
            IDLE: begin
                if (handshake) begin
                    k_nxt     = 3'd0;
                    rbuf_nxt  = 32'd0;
                    en_nxt    = 1'b1;
                    r_nw_nxt  = !req_write;
                    a_nxt     = req_addr;
                    if (req_write) begin
                        dout_nxt = req_wdata[7:0];
                    end
                    state_nxt = req_write ? WRITE : READ;
                end
            end
            WRITE: begin
                if (k == n_bytes - 3'd1) begin
                    state_nxt = RESP;
                    rdata_nxt = 32'd0;
                end else begin
                    k_nxt    = k_inc;
                    en_nxt   = 1'b1;
                    r_nw_nxt = 1'b0;
                    a_nxt    = addr_q + ADDR_WIDTH'(k_inc);
                    dout_nxt = wshift[7:0];
                end
            end
            READ: begin
                if (k != 3'd0) begin
                    rbuf_nxt = rbuf | ({24'd0, ram_din} << {lane, 3'b000});
                end
                if (k == n_bytes) begin
                    state_nxt = RESP;
                    case (n_bytes)
                        3'd1:    rdata_nxt = {{24{signed_q & rbuf_nxt[7]}}, rbuf_nxt[7:0]};
                        3'd2:    rdata_nxt = {{16{signed_q & rbuf_nxt[15]}}, rbuf_nxt[15:0]};
                        default: rdata_nxt = rbuf_nxt;
                    endcase
                end else begin
                    // The final step (k_inc == n_bytes) is the drain cycle on the last address.
                    k_nxt    = k_inc;
                    en_nxt   = 1'b1;
                    r_nw_nxt = 1'b1;
                    if (k_inc < n_bytes) begin
                        a_nxt = addr_q + ADDR_WIDTH'(k_inc);
                    end
                end
            end
            RESP: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (reset) begin
            state      <= IDLE;
            k          <= 3'd0;
            addr_q     <= '0;
            size_q     <= 2'd0;
            signed_q   <= 1'b0;
            wdata_q    <= 32'd0;
            rbuf       <= 32'd0;
            ram_en     <= 1'b0;
            ram_r_nw   <= 1'b1;
            ram_a      <= '0;
            ram_dout   <= 8'd0;
            resp_rdata <= 32'd0;
        end else begin
            state      <= state_nxt;
            k          <= k_nxt;
            rbuf       <= rbuf_nxt;
            ram_en     <= en_nxt;
            ram_r_nw   <= r_nw_nxt;
            ram_a      <= a_nxt;
            ram_dout   <= dout_nxt;
            resp_rdata <= rdata_nxt;
            if (handshake) begin
                addr_q   <= req_addr;
                size_q   <= req_size;
                signed_q <= req_signed;
                wdata_q  <= req_wdata;
            end
        end
    end

endmodule

// File: tb/tb_ram_word_port.sv
// tb/tb_ram_word_port.sv - randomized self-checking bench for ram_word_port
module tb_ram_word_port;

    localparam int AW = 17;
    localparam int MEM_SIZE = 1 << AW;

    logic          clk_in = 1'b0;
    logic          reset = 1'b1;
    logic          ram_ready = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_write = 1'b0;
    logic [1:0]    req_size = 2'd0;
    logic          req_signed = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [31:0]   req_wdata = 32'd0;
    logic          resp_valid;
    logic [31:0]   resp_rdata;
    logic          ram_en;
    logic          ram_r_nw;
    logic [AW-1:0] ram_a;
    logic [7:0]    ram_dout;
    logic [7:0]    ram_din;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0]    mem [MEM_SIZE];
    logic [7:0]    ref_mem [MEM_SIZE];
    logic [AW-1:0] wr_a [$];
    logic [7:0]    wr_d [$];
    int            wr_base;

    always #5 clk_in = ~clk_in;

    ram_word_port #(.ADDR_WIDTH(AW)) dut (
        .clk_in(clk_in), .reset(reset), .ram_ready(ram_ready),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .ram_en(ram_en), .ram_r_nw(ram_r_nw), .ram_a(ram_a),
        .ram_dout(ram_dout), .ram_din(ram_din)
    );

    // Synchronous byte RAM: read data appears the cycle after the address, zero when idle.
    always @(posedge clk_in) begin
        if (reset) begin
            for (int i = 0; i < MEM_SIZE; i++) mem[i] <= 8'h00;
            ram_din <= 8'h00;
        end else begin
            ram_din <= (ram_en && ram_r_nw) ? mem[ram_a] : 8'h00;
            if (ram_en && !ram_r_nw) begin
                mem[ram_a] <= ram_dout;
                wr_a.push_back(ram_a);
                wr_d.push_back(ram_dout);
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int nbytes(input logic [1:0] sz);
        return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    endfunction

    function automatic logic [31:0] model_load(input logic [AW-1:0] a, input logic [1:0] sz,
                                               input logic sg);
        int n;
        logic [31:0] v;
        n = nbytes(sz);
        v = 32'd0;
        for (int i = 0; i < n; i++) v = v | (32'(ref_mem[AW'(int'(a) + i)]) << (8 * i));
        if (sg && n < 4 && v[8 * n - 1]) v = v | (32'hFFFF_FFFF << (8 * n));
        return v;
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        ram_ready = 1'b0;
        req_valid = 1'b0;
        repeat (3) @(negedge clk_in);
        check("rst_req_ready", req_ready, 0);
        check("rst_resp_valid", resp_valid, 0);
        check("rst_resp_rdata", resp_rdata, 0);
        check("rst_ram_en", ram_en, 0);
        check("rst_ram_r_nw", ram_r_nw, 1);
        check("rst_ram_a", ram_a, 0);
        check("rst_ram_dout", ram_dout, 0);
        reset = 1'b0;
        for (int i = 0; i < MEM_SIZE; i++) ref_mem[i] = 8'h00;
        repeat (4) begin
            @(negedge clk_in);
            check("ready_before_clear", req_ready, 0);
        end
        ram_ready = 1'b1;
        #1;
        check("ready_after_clear", req_ready, 1);
    endtask

    // Presents a request, waits for the handshake edge, returns at the negedge of C1.
    task automatic op_start(input logic wr, input logic [1:0] sz, input logic sg,
                            input logic [AW-1:0] a, input logic [31:0] wd, output int waited);
        req_write = wr;
        req_size = sz;
        req_signed = sg;
        req_addr = a;
        req_wdata = wd;
        req_valid = 1'b1;
        wr_base = wr_a.size();
        waited = 0;
        while (!req_ready && waited < 200) begin
            @(negedge clk_in);
            waited++;
        end
        check("handshake_ready", req_ready, 1);
        @(posedge clk_in);
        @(negedge clk_in);
        req_valid = 1'b0;
    endtask

    task automatic op_finish(input logic wr, input logic [1:0] sz, input logic sg,
                             input logic [AW-1:0] a, input logic [31:0] wd,
                             output logic [31:0] got);
        int n, c;
        logic [AW-1:0] ea;
        n = nbytes(sz);
        c = 1;
        while (!resp_valid && c < 12) begin
            @(negedge clk_in);
            c++;
        end
        check(wr ? "store_resp_cycle" : "load_resp_cycle", c, wr ? n + 1 : n + 2);
        got = resp_rdata;
        if (wr) begin
            check("store_rdata", resp_rdata, 0);
            check("store_write_count", wr_a.size() - wr_base, n);
            for (int i = 0; i < n; i++) begin
                ea = AW'(int'(a) + i);
                ref_mem[ea] = 8'((wd >> (8 * i)) & 32'hFF);
                if (wr_base + i < wr_a.size()) begin
                    check("store_byte_addr", wr_a[wr_base + i], ea);
                    check("store_byte_data", wr_d[wr_base + i], ref_mem[ea]);
                end
            end
        end else begin
            check("load_rdata", resp_rdata, model_load(a, sz, sg));
        end
        @(negedge clk_in);
        check("resp_one_cycle", resp_valid, 0);
        check("resp_rdata_held", resp_rdata, got);
        check("ready_after_resp", req_ready, 1);
    endtask

    task automatic do_op(input logic wr, input logic [1:0] sz, input logic sg,
                         input logic [AW-1:0] a, input logic [31:0] wd,
                         output logic [31:0] got);
        int w;
        op_start(wr, sz, sg, a, wd, w);
        op_finish(wr, sz, sg, a, wd, got);
    endtask

    initial begin
        logic [31:0] got;
        int w;
        logic          r_wr, r_sg;
        logic [1:0]    r_sz;
        logic [AW-1:0] r_a;
        logic [31:0]   r_wd;

        do_reset();
        do_op(1'b0, 2'd2, 1'b0, 17'h00000, 32'd0, got);
        check("first_load_zero", got, 32'h0000_0000);

        do_op(1'b1, 2'd2, 1'b0, 17'h00100, 32'hDEAD_BEEF, got);
        do_op(1'b0, 2'd2, 1'b0, 17'h00100, 32'd0, got);
        check("word_deadbeef", got, 32'hDEAD_BEEF);
        do_op(1'b0, 2'd0, 1'b1, 17'h00101, 32'd0, got);
        check("byte_signed", got, 32'hFFFF_FFBE);
        do_op(1'b0, 2'd0, 1'b0, 17'h00101, 32'd0, got);
        check("byte_unsigned", got, 32'h0000_00BE);
        do_op(1'b0, 2'd1, 1'b1, 17'h00102, 32'd0, got);
        check("half_signed", got, 32'hFFFF_DEAD);

        do_op(1'b1, 2'd2, 1'b0, 17'h1FFFE, 32'h1122_3344, got);
        check("wrap_last_addr", wr_a[wr_a.size() - 1], 17'h00001);
        do_op(1'b0, 2'd3, 1'b0, 17'h1FFFE, 32'd0, got);
        check("wrap_load", got, 32'h1122_3344);

        // Back-to-back: the load is held valid throughout the store.
        op_start(1'b1, 2'd1, 1'b0, 17'h00200, 32'h0000_A55A, w);
        req_write = 1'b0;
        req_size = 2'd1;
        req_signed = 1'b1;
        req_addr = 17'h00200;
        req_valid = 1'b1;
        op_finish(1'b1, 2'd1, 1'b0, 17'h00200, 32'h0000_A55A, got);
        op_start(1'b0, 2'd1, 1'b1, 17'h00200, 32'd0, w);
        check("b2b_no_wait", w, 0);
        op_finish(1'b0, 2'd1, 1'b1, 17'h00200, 32'd0, got);
        check("b2b_load", got, 32'hFFFF_A55A);

        for (int t = 0; t < 60; t++) begin
            r_wr = 1'($urandom_range(0, 1));
            r_sz = 2'($urandom_range(0, 3));
            r_sg = 1'($urandom_range(0, 1));
            r_a  = ($urandom_range(0, 1) == 0) ? AW'(32'h100 + $urandom_range(0, 15))
                                                : AW'(32'h1FFFC + $urandom_range(0, 5));
            r_wd = $urandom;
            do_op(r_wr, r_sz, r_sg, r_a, r_wd, got);
        end

        // Reset during C3 of a word load aborts it with no response.
        op_start(1'b0, 2'd2, 1'b0, 17'h00100, 32'd0, w);
        @(negedge clk_in);
        @(negedge clk_in);
        reset = 1'b1;
        ram_ready = 1'b0;
        @(negedge clk_in);
        check("abort_resp_valid", resp_valid, 0);
        check("abort_req_ready", req_ready, 0);
        check("abort_resp_rdata", resp_rdata, 0);
        check("abort_ram_en", ram_en, 0);
        check("abort_ram_r_nw", ram_r_nw, 1);
        check("abort_ram_a", ram_a, 0);
        check("abort_ram_dout", ram_dout, 0);
        do_reset();
        check("abort_no_late_resp", resp_valid, 0);
        do_op(1'b0, 2'd2, 1'b0, 17'h00100, 32'd0, got);
        check("load_after_reclear", got, 32'h0000_0000);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
